// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: ROM read port plus the instruction handshake and jump
// redirect shared with the control unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 18
);
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;

  // master = fetch unit, slave = ROM plus control unit
  modport master (
    output rom_addr, instr, instr_pc, instr_valid,
    input  rom_data, instr_ready, jump_en, jump_addr
  );

  modport slave (
    input  rom_addr, instr, instr_pc, instr_valid,
    output rom_data, instr_ready, jump_en, jump_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the ROM combinationally and
// holds one fetched instruction for the control unit under valid/ready.
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 10,
  parameter int                 INSTR_W  = 18,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    halt,
  output logic                    running,
  instr_fetch_unit_if.master      bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_instr_valid;

  logic               w_slot_free;
  logic [ADDR_W-1:0]  w_pc_next;

  // The slot can take a new word when it is empty or being consumed now.
  assign w_slot_free = !r_instr_valid || bus.instr_ready;
  assign w_pc_next   = r_pc + ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values; blocking ones here would let r_pc+1 leak into r_instr_pc.
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (halt) begin
            r_state       <= ST_IDLE;
            r_instr_valid <= 1'b0;
            if (bus.jump_en) r_pc <= bus.jump_addr;
          end else if (bus.jump_en) begin
            r_pc          <= bus.jump_addr;
            r_instr_valid <= 1'b0;
          end else if (w_slot_free) begin
            r_instr       <= bus.rom_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= w_pc_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr    = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;
  assign running         = (r_state == ST_RUN);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stall, jump, wrap,
// halt-with-jump and asynchronous reset, sampled on the falling edge.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 18;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic halt;
  logic running;

  logic [INSTR_W-1:0] rom [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  assign bus.rom_data = rom[bus.rom_addr];

  instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC('0)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .halt    (halt),
    .running (running),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_valid,
                           input logic [31:0] e_instr, input logic [31:0] e_ipc,
                           input logic [31:0] e_addr);
    check({tag, ".valid"},    32'(bus.instr_valid), e_valid);
    check({tag, ".instr"},    32'(bus.instr),       e_instr);
    check({tag, ".instr_pc"}, 32'(bus.instr_pc),    e_ipc);
    check({tag, ".rom_addr"}, 32'(bus.rom_addr),    e_addr);
  endtask

  task automatic do_jump(input logic [ADDR_W-1:0] target);
    bus.jump_en   = 1'b1;
    bus.jump_addr = target;
    step();
    bus.jump_en   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 18'h10000 | 18'(i);
    rom[0]      = 18'h00001;
    rom[1]      = 18'h04002;
    rom[2]      = 18'h08003;
    rom[3]      = 18'h0C004;
    rom[10'h200] = 18'h24ABC;
    rom[10'h3FF] = 18'h3FFFF;

    reset = 1'b1; start = 1'b0; halt = 1'b0;
    bus.instr_ready = 1'b1; bus.jump_en = 1'b0; bus.jump_addr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst.running", 32'(running), 0);
    check_out("rst", 0, 0, 0, 0);

    // IDLE ignores jump_en.
    bus.jump_en = 1'b1; bus.jump_addr = 10'h055;
    step(); step();
    bus.jump_en = 1'b0;
    check("idle.running", 32'(running), 0);
    check_out("idle", 0, 0, 0, 0);

    // Start: nothing captured on the start edge.
    start = 1'b1;
    step();
    start = 1'b0;
    check("start.running", 32'(running), 1);
    check_out("start", 0, 0, 0, 0);
    step(); check_out("s0", 1, 18'h00001, 0, 1);
    step(); check_out("s1", 1, 18'h04002, 1, 2);
    step(); check_out("s2", 1, 18'h08003, 2, 3);

    // Stall three cycles at instr_pc=2.
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_out("stall", 1, 18'h08003, 2, 3);
    end
    bus.instr_ready = 1'b1;
    step(); check_out("unstall", 1, 18'h0C004, 3, 4);

    // Rewind to 0, then jump from instr_pc=1 to 0x200.
    do_jump(10'h000);
    check_out("rewind.bubble", 0, 18'h0C004, 3, 0);
    step(); check_out("rw0", 1, 18'h00001, 0, 1);
    step(); check_out("rw1", 1, 18'h04002, 1, 2);
    do_jump(10'h200);
    check("jmp.bubble.valid", 32'(bus.instr_valid), 0);
    check("jmp.bubble.addr",  32'(bus.rom_addr), 32'h200);
    step(); check_out("jmp.tgt", 1, 18'h24ABC, 32'h200, 32'h201);

    // PC wrap from 0x3FF to 0.
    do_jump(10'h3FF);
    check("wrap.bubble.valid", 32'(bus.instr_valid), 0);
    step(); check_out("wrap.top", 1, 18'h3FFFF, 32'h3FF, 0);
    step(); check_out("wrap.zero", 1, 18'h00001, 0, 1);

    // Halt with simultaneous jump: PC loads target, unit goes idle.
    halt = 1'b1;
    bus.jump_en = 1'b1; bus.jump_addr = 10'h010;
    step();
    halt = 1'b0; bus.jump_en = 1'b0;
    check("halt.running", 32'(running), 0);
    check("halt.valid",   32'(bus.instr_valid), 0);
    check("halt.addr",    32'(bus.rom_addr), 32'h010);
    step();
    check("halt.idle.addr", 32'(bus.rom_addr), 32'h010);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); check_out("restart", 1, 18'h10010, 32'h010, 32'h011);

    // Asynchronous reset mid-cycle with a valid instruction held.
    #2 reset = 1'b1;
    #1;
    check("arst.running", 32'(running), 0);
    check_out("arst", 0, 0, 0, 0);
    #1 reset = 1'b0;
    step(); step();
    check("arst.idle.running", 32'(running), 0);
    check_out("arst.idle", 0, 0, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); check_out("arst.restart", 1, 18'h00001, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
